// File: rtl/pool_pkg.sv
// Shared pooler/collector definitions: FSM state type, default geometry, count-width helper.
package pool_pkg;

  localparam int POOL_DATA_WIDTH = 8;
  localparam int POOL_OUT_SIZE   = 13;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } pool_state_e;

  // Width able to hold 0..depth inclusive.
  function automatic int pool_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pool_collect_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port, array not reset.
module pool_collect_ram #(
  parameter int DEPTH = 169,
  parameter int DW    = 8,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its value when re is low, which gives the stall behaviour for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pool_collector.sv
// Captures one OUT_SIZE x OUT_SIZE pooled map and replays it over a valid/ready port.
// Optional POOL_COLLECT_CHECKSUM_EN adds a 16-bit running sum of stored samples.
module pool_collector
  import pool_pkg::*;
#(
  parameter  int OUT_SIZE   = POOL_OUT_SIZE,
  parameter  int DATA_WIDTH = POOL_DATA_WIDTH,
  localparam int DEPTH      = OUT_SIZE * OUT_SIZE,
  localparam int CW         = pool_cw(DEPTH),
  localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  master_rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  input  logic                  end_in,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic [CW-1:0]         count,
  output logic                  done,
`ifdef POOL_COLLECT_CHECKSUM_EN
  output logic [15:0]           checksum,
`endif
  output logic                  short_err,
  output logic                  stray_err
);

  pool_state_e   state, state_nxt;
  logic [CW-1:0] wr_ptr, rd_ptr;
  logic          wr_en, rd_en;
  logic [AW-1:0] rd_addr;
  logic          sample, hs;

  assign sample = valid_in && !end_in;
  assign hs     = rd_valid && rd_ready;

  always_ff @(posedge clk or negedge master_rst_n) begin
    if (!master_rst_n) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CAPTURE;
      CAPTURE: begin
        if (end_in)                                     state_nxt = (count != '0) ? DRAIN : IDLE;
        else if (valid_in && wr_ptr == CW'(DEPTH - 1))  state_nxt = DRAIN;
      end
      DRAIN:   if (hs && rd_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read address runs one ahead of rd_ptr so the next entry lands on the handshake edge.
  always_comb begin
    wr_en   = (state == CAPTURE) && sample;
    rd_en   = 1'b0;
    rd_addr = '0;
    if (state == DRAIN) begin
      if (!rd_valid) begin
        rd_en = 1'b1;
      end else if (hs && !rd_last) begin
        rd_en   = 1'b1;
        rd_addr = AW'(rd_ptr + CW'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge master_rst_n) begin
    if (!master_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      done      <= 1'b0;
      short_err <= 1'b0;
      stray_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            wr_ptr    <= '0;
            count     <= '0;
            short_err <= 1'b0;
            stray_err <= sample;
          end else if (sample) begin
            stray_err <= 1'b1;
          end
        end
        CAPTURE: begin
          if (end_in) begin
            short_err <= 1'b1;
            if (count == '0) done <= 1'b1;
          end else if (valid_in) begin
            wr_ptr <= wr_ptr + CW'(1);
            count  <= count + CW'(1);
          end
        end
        DRAIN: begin
          if (sample) stray_err <= 1'b1;
          if (!rd_valid) begin
            rd_valid <= 1'b1;
            rd_ptr   <= '0;
            rd_last  <= (count == CW'(1));
          end else if (hs) begin
            if (rd_last) begin
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
              done     <= 1'b1;
            end else begin
              rd_ptr  <= rd_ptr + CW'(1);
              rd_last <= (CW'(rd_ptr + CW'(2)) == count);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef POOL_COLLECT_CHECKSUM_EN
  always_ff @(posedge clk or negedge master_rst_n) begin
    if (!master_rst_n)                    checksum <= '0;
    else if (state == IDLE && start)      checksum <= '0;
    else if (wr_en)                       checksum <= checksum + 16'(data_in);
  end
`endif

  pool_collect_ram #(
    .DEPTH (DEPTH),
    .DW    (DATA_WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (master_rst_n),
    .we    (wr_en),
    .waddr (AW'(wr_ptr)),
    .wdata (data_in),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_pool_collector.sv
// Scoreboard bench for pool_collector: frames queued on capture, checked by a separate read-port monitor.
module tb_pool_collector;

  localparam int DW    = 8;
  localparam int DEPTH = 169;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          master_rst_n = 1'b0;
  logic          start = 1'b0, valid_in = 1'b0, end_in = 1'b0, rd_ready = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, rd_last, done, short_err, stray_err;
  logic [CW-1:0] count;
`ifdef POOL_COLLECT_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  pool_collector dut (
    .clk          (clk),
    .master_rst_n (master_rst_n),
    .start        (start),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .end_in       (end_in),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_last      (rd_last),
    .count        (count),
    .done         (done),
`ifdef POOL_COLLECT_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .short_err    (short_err),
    .stray_err    (stray_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int ready_mode = 0;

  typedef struct { logic [DW-1:0] d; logic l; } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Ready pattern changes just after each edge so the monitor and DUT see the same value.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       rd_ready = 1'b1;
        1:       begin rd_ready = (ph == 0 || ph == 3); ph = (ph + 1) % 4; end
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops on every read handshake, checks stall stability and the done pulse.
  initial begin
    logic          stall = 1'b0, last_hs = 1'b0, sl = 1'b0;
    logic [DW-1:0] sd = '0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (!master_rst_n) begin
        stall = 1'b0; last_hs = 1'b0;
      end else begin
        if (last_hs) chk("done_after_last", {30'd0, done, rd_valid}, 32'h2);
        if (stall) begin
          chk("stall_valid", 32'(rd_valid), 32'd1);
          chk("stall_data", 32'(rd_data), 32'(sd));
          chk("stall_last", 32'(rd_last), 32'(sl));
        end
        stall = rd_valid && !rd_ready; sd = rd_data; sl = rd_last;
        last_hs = 1'b0;
        if (rd_valid && rd_ready) begin
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rd: got %0h want none", rd_data);
          end else begin
            e = q.pop_front();
            chk("rd_data", 32'(rd_data), 32'(e.d));
            chk("rd_last", 32'(rd_last), 32'(e.l));
            last_hs = rd_last;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 3000);
    chk({nm, "_done"}, 32'(done), 32'd1);
    step();
  endtask

  // mode 0: base+i, 1: random, 2: constant base
  task automatic run_frame(input string nm, input int n, input int mode, input logic [DW-1:0] base,
                           input bit start_stray, input bit drain_stray, input bit gaps);
    logic [DW-1:0] v, first;
    int sum = 0;
    first = '0;
    start = 1'b1; valid_in = start_stray; end_in = 1'b0; data_in = 8'h5A;
    step();
    start = 1'b0; valid_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        valid_in = 1'b0; data_in = 8'($urandom); step();
      end
      v = (mode == 0) ? 8'(base + 8'(i)) : (mode == 1) ? 8'($urandom) : base;
      if (i == 0) first = v;
      data_in = v; valid_in = 1'b1;
      q.push_back('{d: v, l: (i == n - 1)});
      sum += int'(v);
      step();
    end
    if (n < DEPTH) begin
      end_in = 1'b1; valid_in = 1'b1; data_in = 8'($urandom);
      step();
      end_in = 1'b0;
    end
    valid_in = 1'b0;
    if (drain_stray) begin
      valid_in = 1'b1; data_in = 8'($urandom);
      step(); step();
      valid_in = 1'b0;
    end else if (n == DEPTH) begin
      chk({nm, "_rv_early"}, 32'(rd_valid), 32'd0);
      step();
      chk({nm, "_rv_first"}, 32'(rd_valid), 32'd1);
      chk({nm, "_rd_first"}, 32'(rd_data), 32'(first));
    end
    wait_done(nm);
    chk({nm, "_count"}, 32'(count), 32'(n));
    chk({nm, "_short"}, 32'(short_err), 32'(n < DEPTH));
    chk({nm, "_stray"}, 32'(stray_err), 32'(start_stray || drain_stray));
    chk({nm, "_drained"}, 32'(q.size()), 32'd0);
`ifdef POOL_COLLECT_CHECKSUM_EN
    chk({nm, "_checksum"}, 32'(checksum), 32'(sum & 16'hFFFF));
`endif
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_rv"}, 32'(rd_valid), 32'd0);
    chk({nm, "_rl"}, 32'(rd_last), 32'd0);
    chk({nm, "_rd"}, 32'(rd_data), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_count"}, 32'(count), 32'd0);
    chk({nm, "_errs"}, {30'd0, short_err, stray_err}, 32'd0);
`ifdef POOL_COLLECT_CHECKSUM_EN
    chk({nm, "_cks"}, 32'(checksum), 32'd0);
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset("reset");
    @(posedge clk); #1; master_rst_n = 1'b1;
    step();

    ready_mode = 0; run_frame("full_inc", DEPTH, 0, 8'h00, 0, 0, 0);
    ready_mode = 1; run_frame("full_bp", DEPTH, 1, 8'h00, 0, 0, 0);
    ready_mode = 0; run_frame("short5", 5, 0, 8'hA1, 0, 0, 0);
    run_frame("short0", 0, 1, 8'h00, 0, 0, 0);

    // Stray sample while idle: flag set, count untouched.
    run_frame("pre_stray", 7, 1, 8'h00, 0, 0, 0);
    valid_in = 1'b1; data_in = 8'h3C; step(); valid_in = 1'b0;
    @(negedge clk);
    chk("idle_stray", 32'(stray_err), 32'd1);
    chk("idle_stray_count", 32'(count), 32'd7);
    step();

    ready_mode = 2; run_frame("full_strays", DEPTH, 1, 8'h00, 1, 1, 1);
    run_frame("rand_short", $urandom_range(1, DEPTH - 1), 1, 8'h00, 0, 1, 1);

    // Abandon a frame mid-capture; outputs must clear asynchronously.
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 50; i++) begin valid_in = 1'b1; data_in = 8'($urandom); step(); end
    valid_in = 1'b0; master_rst_n = 1'b0;
    #1; chk_reset("midrst");
    q.delete();
    @(posedge clk); #1; master_rst_n = 1'b1;
    step();
    ready_mode = 1; run_frame("after_rst", DEPTH, 0, 8'h40, 0, 0, 0);

    ready_mode = 0; run_frame("all_ff", DEPTH, 2, 8'hFF, 0, 0, 0);
`ifdef POOL_COLLECT_CHECKSUM_EN
    chk("cks_a857", 32'(checksum), 32'hA857);
`endif
    run_frame("cks_restart", 3, 2, 8'h10, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      ready_mode = 2;
      run_frame("rand_loop", $urandom_range(1, DEPTH), 1, 8'h00, 0, 0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pool_collector.md
Name: pool_collector

Overview:
- Receiving end of the pooler output stream (data_out / valid_op / end_op).
- Captures one pooled feature map of OUT_SIZE*OUT_SIZE samples, in raster order, into an internal buffer.
- Replays the buffer to the next layer over a valid/ready read port.
- Flags short frames and stray samples so layer sequencing errors surface in simulation and silicon.

Parameters:
- OUT_SIZE, 13, pooled map side (INPUT_SIZE/POOL_SIZE of the upstream pooler).
- DATA_WIDTH, 8, sample width.
- DEPTH, OUT_SIZE*OUT_SIZE, localparam, buffer entries. Pointer/count width CW = $clog2(DEPTH+1).

Ports:
- clk  in  1  single clock, rising edge.
- master_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle arm pulse; honoured only in IDLE.
- data_in  in  DATA_WIDTH  pooled sample (pooler data_out).
- valid_in  in  1  pooler valid_op.
- end_in  in  1  pooler end_op; a beat with end_in=1 is never stored.
- rd_ready  in  1  downstream accepts rd_data.
- rd_data  out  DATA_WIDTH  replayed sample.
- rd_valid  out  1  rd_data valid.
- rd_last  out  1  high with final replayed sample.
- count  out  CW  samples captured in current/last frame.
- done  out  1  one-cycle pulse on return to IDLE after drain.
- short_err  out  1  sticky: end_in seen before DEPTH samples.
- stray_err  out  1  sticky: valid_in&&!end_in outside CAPTURE.

Behaviour:
- Reset (async, master_rst_n=0): state=IDLE; wr_ptr, rd_ptr, count=0; rd_valid, rd_last, done, short_err, stray_err=0; rd_data=0. Buffer contents are not cleared. Reset mid-capture or mid-drain abandons the frame immediately.
- FSM states: IDLE, CAPTURE, DRAIN.
- IDLE:
  - start=1 -> CAPTURE next cycle; wr_ptr=0, count=0, both error flags cleared.
  - A sample in the start cycle is not stored and sets stray_err.
- CAPTURE:
  - Each cycle with valid_in=1 && end_in=0 writes mem[wr_ptr]=data_in; wr_ptr and count increment.
  - Write of entry DEPTH-1 -> DRAIN next cycle.
  - end_in=1 with count<DEPTH -> short_err=1; if count>0 go to DRAIN, else go to IDLE with done pulse.
  - start is ignored.
- DRAIN:
  - rd_valid rises the cycle after entry with rd_data=mem[0].
  - Each rd_valid&&rd_ready advances rd_ptr, one element per cycle at full throughput. The next entry is loaded into the output register the same edge, with no bubble.
  - rd_data and rd_last hold stable while rd_valid&&!rd_ready.
  - rd_last=1 exactly when rd_ptr==count-1.
  - Handshake on rd_last -> rd_valid=0, done=1 for one cycle, state IDLE.
  - Samples arriving in DRAIN are dropped and set stray_err.
- count holds its final value in IDLE until the next start.
- Samples are raw bit patterns: no arithmetic, no sign interpretation.

Optional Feature:
- Macro: POOL_COLLECT_CHECKSUM_EN.
- Defined:
  - Extra output checksum [15:0] = modulo-2^16 sum of all stored samples (zero-extended).
  - Cleared on start; updated on each stored write; held through DRAIN and IDLE; reset value 0.
- Undefined: port and accumulator absent; all other behaviour identical.

Decomposition:
- Shared package pool_pkg holds:
  - FSM state typedef (IDLE/CAPTURE/DRAIN).
  - Default DATA_WIDTH and OUT_SIZE constants, shared with the pooler.
  - CW width helper.
- One sub-module, pool_collect_ram: simple dual-port, one write port, registered read port, DEPTH x DATA_WIDTH, no reset on the array.
- FSM, pointers and flags stay in pool_collector.

Test Plan:
- Full frame, rd_ready=1: start, then 169 samples 0..168 -> count=169; rd_valid the cycle after the last write; rd_data 0..168 on consecutive cycles; rd_last with 168; done one cycle later; no error flags.
- Backpressure: full frame, rd_ready toggling 1-0-0-1 -> rd_data and rd_last stable during stalls; all 169 values in order, no duplicates.
- Short frame: start, 5 samples 0xA1..0xA5, then end_in=1 -> short_err=1, count=5; replay A1..A5 with rd_last on A5. Repeat with end_in and zero samples -> done pulse, no rd_valid.
- Stray samples: valid_in in IDLE, and valid_in during DRAIN -> stray_err=1; stored data and count unchanged. Next start clears both flags.
- Reset mid-operation: master_rst_n low after 50 samples -> all outputs at reset values immediately. A new start plus a full frame replays correctly.
- Checksum (macro defined): 169 samples all 0xFF -> checksum=0xA857. Second frame after start restarts from 0.
